// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: execute-stage branch resolution, 2-bit BHT for fetch prediction, saturating perf counters
module branch_resolve_unit #(
    parameter int PC_W  = 32,
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  pcF,
    output logic             predTakenF,
    input  logic             validE,
    input  logic             branchE,
    input  logic             jumpE,
    input  logic [2:0]       condE,
    input  logic             zeroE,
    input  logic             negativeE,
    input  logic [PC_W-1:0]  pcE,
    input  logic             predTakenE,
    output logic             pcSrcE,
    output logic             recoverE,
    output logic             mispredictE,
    output logic             flushD,
    output logic             flushE,
    output logic [CNT_W-1:0] branchCount,
    output logic [CNT_W-1:0] mispredCount
);
    logic [1:0]       bht [2**IDX_W];
    logic [IDX_W-1:0] idxF, idxE;
    logic             condMet, takenE, update;
    logic [1:0]       curE, nextE;

    assign idxF = pcF[IDX_W+1:2];
    assign idxE = pcE[IDX_W+1:2];

    // Resolve the branch condition, outcome, misprediction and the saturating next BHT state
    always_comb begin
        condMet     = condE == 3'd0 ? zeroE :
                      condE == 3'd1 ? !zeroE :
                      condE == 3'd2 ? negativeE :
                      condE == 3'd3 ? !negativeE :
                      condE == 3'd4 ? (zeroE | negativeE) :
                      condE == 3'd5 ? (!zeroE & !negativeE) :
                      condE == 3'd6;
        takenE      = validE & (jumpE | (branchE & condMet));
        mispredictE = validE & (takenE != predTakenE);
        pcSrcE      = mispredictE & takenE;
        recoverE    = mispredictE & !takenE;
        flushD      = mispredictE;
        flushE      = mispredictE;
        update      = validE & branchE & !jumpE;
        curE        = bht[idxE];
        nextE       = condMet ? (curE == 2'b11 ? curE : curE + 2'd1)
                              : (curE == 2'b00 ? curE : curE - 2'd1);
        predTakenF  = rst ? 1'b0 : (update && idxF == idxE) ? nextE[1] : bht[idxF][1];
    end

    // Train the BHT on conditional branches and count branches and mispredictions, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**IDX_W; i++) bht[i] <= 2'b01;
            branchCount  <= '0;
            mispredCount <= '0;
        end else begin
            if (update) bht[idxE] <= nextE;
            if (update && !(&branchCount)) branchCount <= branchCount + 1'b1;
            if (mispredictE && !(&mispredCount)) mispredCount <= mispredCount + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: randomized and directed checks of branch_resolve_unit against a behavioural model
module tb_branch_resolve_unit;
    logic        clk = 0, rst = 1;
    logic [31:0] pcF = 0, pcE = 0;
    logic        validE = 0, branchE = 0, jumpE = 0, zeroE = 0, negativeE = 0, predTakenE = 0;
    logic [2:0]  condE = 0;
    logic        predTakenF, pcSrcE, recoverE, mispredictE, flushD, flushE;
    logic [15:0] branchCount, mispredCount;
    logic        predTakenF2, pcSrcE2, recoverE2, mispredictE2, flushD2, flushE2;
    logic [3:0]  branchCount2, mispredCount2;

    int tests = 0, fails = 0;
    int bhtM [16];
    int bcM = 0, mcM = 0;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk(clk), .rst(rst), .pcF(pcF), .predTakenF(predTakenF), .validE(validE),
        .branchE(branchE), .jumpE(jumpE), .condE(condE), .zeroE(zeroE), .negativeE(negativeE),
        .pcE(pcE), .predTakenE(predTakenE), .pcSrcE(pcSrcE), .recoverE(recoverE),
        .mispredictE(mispredictE), .flushD(flushD), .flushE(flushE),
        .branchCount(branchCount), .mispredCount(mispredCount)
    );

    // Narrow-counter copy so counter saturation is reachable in a short run
    branch_resolve_unit #(.CNT_W(4)) dutSat (
        .clk(clk), .rst(rst), .pcF(pcF), .predTakenF(predTakenF2), .validE(validE),
        .branchE(branchE), .jumpE(jumpE), .condE(condE), .zeroE(zeroE), .negativeE(negativeE),
        .pcE(pcE), .predTakenE(predTakenE), .pcSrcE(pcSrcE2), .recoverE(recoverE2),
        .mispredictE(mispredictE2), .flushD(flushD2), .flushE(flushE2),
        .branchCount(branchCount2), .mispredCount(mispredCount2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit condModel(input int c, input bit z, input bit n);
        case (c)
            0: return z;
            1: return !z;
            2: return n;
            3: return !n;
            4: return z || n;
            5: return !z && !n;
            6: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int sat(input int v, input int lim);
        return v > lim ? lim : v;
    endfunction

    task automatic resetModel();
        for (int i = 0; i < 16; i++) bhtM[i] = 1;
        bcM = 0;
        mcM = 0;
    endtask

    task automatic doStep(input logic [31:0] f, input bit v, input bit b, input bit j,
                          input int c, input bit z, input bit n, input logic [31:0] e, input bit pt);
        int  iF, iE, nxt;
        bit  met, tk, mis, upd, expPred;
        @(negedge clk);
        pcF = f; validE = v; branchE = b; jumpE = j; condE = 3'(c);
        zeroE = z; negativeE = n; pcE = e; predTakenE = pt;
        #1;
        iF  = int'(f[5:2]);
        iE  = int'(e[5:2]);
        met = condModel(c, z, n);
        tk  = v && (j || (b && met));
        mis = v && (tk != pt);
        upd = v && b && !j;
        nxt = met ? (bhtM[iE] < 3 ? bhtM[iE] + 1 : 3) : (bhtM[iE] > 0 ? bhtM[iE] - 1 : 0);
        expPred = (upd && iF == iE) ? (nxt >= 2) : (bhtM[iF] >= 2);
        check("predTakenF", 32'(predTakenF), 32'(expPred));
        check("predTakenF_sat", 32'(predTakenF2), 32'(expPred));
        check("pcSrcE", 32'(pcSrcE), 32'(mis && tk));
        check("recoverE", 32'(recoverE), 32'(mis && !tk));
        check("mispredictE", 32'(mispredictE), 32'(mis));
        check("flushD", 32'(flushD), 32'(mis));
        check("flushE", 32'(flushE), 32'(mis));
        @(posedge clk);
        if (upd) begin
            bhtM[iE] = nxt;
            bcM++;
        end
        if (mis) mcM++;
        #1;
        check("branchCount", 32'(branchCount), 32'(sat(bcM, 65535)));
        check("mispredCount", 32'(mispredCount), 32'(sat(mcM, 65535)));
        check("branchCount_sat", 32'(branchCount2), 32'(sat(bcM, 15)));
        check("mispredCount_sat", 32'(mispredCount2), 32'(sat(mcM, 15)));
    endtask

    task automatic sweepIdle();
        for (int i = 0; i < 16; i++) doStep(32'(i * 4), 0, 1, 0, 0, 1, 0, 32'(i * 4), 1);
    endtask

    initial begin
        resetModel();
        #12;
        check("rst_predTakenF", 32'(predTakenF), 0);
        check("rst_branchCount", 32'(branchCount), 0);
        check("rst_mispredCount", 32'(mispredCount), 0);
        @(negedge clk);
        rst = 0;
        sweepIdle();
        doStep(32'h40, 1, 1, 0, 0, 1, 0, 32'h40, 0);
        doStep(32'h40, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        check("bht_0x40_taken", 32'(predTakenF), 1);
        for (int c = 0; c < 8; c++)
            for (int zn = 0; zn < 3; zn++)
                doStep(32'h100, 1, 1, 0, c, zn[1], zn[0], 32'(32'h80 + c * 4), 0);
        for (int k = 0; k < 4; k++) doStep(32'h48, 1, 1, 0, 6, 0, 0, 32'h48, 1);
        doStep(32'h48, 1, 1, 0, 7, 0, 0, 32'h48, 1);
        doStep(32'h48, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        check("sat_predTakenF", 32'(predTakenF), 1);
        doStep(32'h48, 1, 0, 0, 0, 0, 0, 32'h48, 1);
        doStep(32'h0C, 1, 1, 0, 1, 0, 0, 32'h0C, 0);
        doStep(32'h0C, 1, 0, 1, 7, 0, 0, 32'h1C, 0);
        doStep(32'h0C, 1, 1, 1, 7, 0, 0, 32'h0C, 1);
        for (int k = 0; k < 400; k++) begin
            logic [31:0] e, f;
            e = {$urandom_range(0, 255), 2'($urandom)} & 32'h3FF;
            e[5:2] = 4'($urandom_range(0, 15));
            f = ($urandom_range(0, 1) == 1) ? {e[31:6] ^ 26'($urandom), e[5:0]} : $urandom;
            doStep(f, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0,
                   $urandom_range(0, 7), 1'($urandom), 1'($urandom), e, 1'($urandom));
        end
        @(negedge clk);
        pcF = 32'h0C; pcE = 32'h0C; validE = 1; branchE = 1; jumpE = 0; condE = 3'd6; predTakenE = 0;
        #2;
        rst = 1;
        #1;
        resetModel();
        check("midrst_branchCount", 32'(branchCount), 0);
        check("midrst_mispredCount", 32'(mispredCount), 0);
        check("midrst_predTakenF", 32'(predTakenF), 0);
        @(posedge clk);
        #1;
        check("rst_hold_predTakenF", 32'(predTakenF), 0);
        check("rst_hold_branchCount", 32'(branchCount), 0);
        @(negedge clk);
        validE = 0;
        rst = 0;
        sweepIdle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage branch resolution unit for the pipelined core; next generation of the Execute PC-source gate.
- Resolves conditional branches against ALU flags under a selectable condition code, handles unconditional jumps, and owns a 2-bit saturating branch history table (BHT) read by Fetch.
- Detects mispredictions, generates pipeline flush and PC-select controls, and keeps saturating performance counters.

Parameters:
- PC_W, 32, program counter width.
- IDX_W, 4, BHT index width; table holds 2**IDX_W entries, indexed by pc[IDX_W+1:2].
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- pcF  input  PC_W  Fetch-stage PC used for the BHT lookup.
- predTakenF  output  1  Fetch prediction, combinational: BHT[idx(pcF)][1] (with bypass, see Behaviour).
- validE  input  1  Execute holds a real instruction (not a bubble).
- branchE  input  1  instruction is a conditional branch.
- jumpE  input  1  instruction is an unconditional jump.
- condE  input  3  condition code.
- zeroE  input  1  ALU zero flag.
- negativeE  input  1  ALU negative flag.
- pcE  input  PC_W  Execute-stage PC used for the BHT update.
- predTakenE  input  1  prediction made in Fetch for this instruction, carried down the pipe.
- pcSrcE  output  1  1 selects the branch/jump target as the next PC.
- recoverE  output  1  1 selects pcPlus4E; recovery from a false taken prediction.
- mispredictE  output  1  prediction did not match the resolved outcome.
- flushD  output  1  flush Decode; equals mispredictE.
- flushE  output  1  flush Execute input register; equals mispredictE.
- branchCount  output  CNT_W  resolved conditional branches.
- mispredCount  output  CNT_W  mispredictions.

Behaviour:
- Condition codes (condE): 000 EQ = Z; 001 NE = !Z; 010 LT = N; 011 GE = !N; 100 LE = Z|N; 101 GT = !Z&!N; 110 AL = 1; 111 NV = 0.
- condMet = condition-code decode of zeroE/negativeE.
- takenE = validE & (jumpE | (branchE & condMet)). If jumpE and branchE are both 1, jumpE wins.
- Decisions are combinational, with zero latency:
  - mispredictE = validE & (takenE != predTakenE). This covers a non-branch aliased to a predicted-taken entry.
  - pcSrcE = mispredictE & takenE.
  - recoverE = mispredictE & !takenE.
  - pcSrcE and recoverE are never both 1.
- When validE = 0, all decision outputs are 0 regardless of other inputs.
- BHT update:
  - Occurs on the rising clk edge only when validE & branchE & !jumpE.
  - Entry idx(pcE) increments when condMet and decrements otherwise, saturating at 11 and 00.
  - Jumps and non-branches never update the BHT.
- BHT read:
  - predTakenF = MSB of entry idx(pcF).
  - Same-cycle bypass: if an update is occurring and idx(pcF) == idx(pcE), predTakenF reflects the post-update value.
- Counters (rising edge, saturating at all-ones, no wrap):
  - branchCount increments when validE & branchE & !jumpE.
  - mispredCount increments when mispredictE.
  - Both increment in the same cycle when both conditions hold.
- Reset (async, active-high):
  - Every BHT entry goes to 01 (weakly not-taken).
  - Both counters go to 0.
  - Reset mid-operation discards the in-flight update.
  - While rst = 1, predTakenF = 0.
  - Combinational outputs follow their inputs; the pipeline registers gate validE.
- Table rules:
  - Table depth is exactly 2**IDX_W; no associativity, no tags, aliasing is accepted.
  - pc[1:0] is ignored.

Test Plan:
- Reset, then sweep pcF over 16 indices -> predTakenF = 0 everywhere; branchCount = mispredCount = 0.
- validE=1, branchE=1, condE=000, zeroE=1, predTakenE=0 -> pcSrcE=1, mispredictE=flushD=flushE=1; next cycle the entry for pcE=0x40 is 10 and predTakenF(pcF=0x40)=1; branchCount=1, mispredCount=1.
- Condition matrix: each condE with (Z,N) in {00, 01, 10} -> takenE matches the table (e.g. GT with Z=0,N=0 taken; LE with Z=0,N=0 not taken; NV never taken).
- Saturation: four taken updates on one index, then one not-taken -> states 01→10→11→11→11→10; predTakenF stays 1.
- Alias recovery: validE=1, branchE=jumpE=0, predTakenE=1 -> recoverE=1, pcSrcE=0, mispredictE=1; BHT unchanged.
- Bypass and reset: update idx 3 to taken while pcF hits idx 3 -> predTakenF=1 in the same cycle. Force mispredCount to all-ones, mispredict once -> count holds at 0xFFFF. Assert rst mid-cycle -> counters 0, entries 01 immediately.
